// File: rtl/game_defs.sv
// Shared screen/mode definitions for the game controller
// and the background renderer that consumes mode.
package game_defs;

  localparam logic [2:0] MODE_START = 3'd0;
  localparam logic [2:0] MODE_PLAY1 = 3'd1;
  localparam logic [2:0] MODE_PLAY2 = 3'd2;
  localparam logic [2:0] MODE_OVER  = 3'd3;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_PLAY1 = 2'd1,
    S_PLAY2 = 2'd2,
    S_OVER  = 2'd3
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability
// counter and rising-edge press pulse.
module btn_debounce #(
  parameter int unsigned CYC = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic press_o
);

  localparam int unsigned CW = (CYC > 1) ? $clog2(CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYC - 1);

  logic          s1_q;
  logic          s2_q;
  logic          deb_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // bring the raw button into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_raw_i;
      s2_q <= s1_q;
    end
  end

  // level flips after CYC straight cycles of disagreement;
  // the press pulse fires on the cycle it flips to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q   <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      press_q <= 1'b0;
      if (s2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        deb_q   <= s2_q;
        press_q <= s2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/game_mode_ctrl.sv
// Screen sequencer: start menu, one/two-player game,
// and a timed game-over screen.
module game_mode_ctrl
  import game_defs::*;
#(
  parameter int unsigned DEBOUNCE_CYC  = 250000,
  parameter int unsigned OVER_HOLD_CYC = 75000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_sel_raw,
  input  logic       btn_start_raw,
  input  logic       player_dead,
  output logic [2:0] mode,
  output logic       btn_mode_sel,
  output logic       game_init
);

  localparam int unsigned HW =
    (OVER_HOLD_CYC > 1) ? $clog2(OVER_HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(OVER_HOLD_CYC - 1);

  state_e        state_q;
  logic [2:0]    mode_q;
  logic          cur_q;
  logic          init_q;
  logic [HW-1:0] hold_q;
  logic          sel_press;
  logic          start_press;

  btn_debounce #(
    .CYC(DEBOUNCE_CYC)
  ) u_sel (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw_i (btn_sel_raw),
    .press_o   (sel_press)
  );

  btn_debounce #(
    .CYC(DEBOUNCE_CYC)
  ) u_start (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw_i (btn_start_raw),
    .press_o   (start_press)
  );

  // screen FSM; mode, cursor and init pulse move with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_START;
      mode_q  <= MODE_START;
      cur_q   <= 1'b1;
      init_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      init_q <= 1'b0;
      unique case (state_q)
        S_START: begin
          if (start_press) begin
            state_q <= cur_q ? S_PLAY1 : S_PLAY2;
            mode_q  <= cur_q ? MODE_PLAY1 : MODE_PLAY2;
            init_q  <= 1'b1;
          end else if (sel_press) begin
            cur_q <= ~cur_q;
          end
        end
        S_PLAY1, S_PLAY2: begin
          if (player_dead) begin
            state_q <= S_OVER;
            mode_q  <= MODE_OVER;
            hold_q  <= '0;
          end
        end
        S_OVER: begin
          if (start_press || hold_q == HOLD_MAX) begin
            state_q <= S_START;
            mode_q  <= MODE_START;
            cur_q   <= 1'b1;
            hold_q  <= '0;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: begin
          state_q <= S_START;
          mode_q  <= MODE_START;
          cur_q   <= 1'b1;
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign mode         = mode_q;
  assign btn_mode_sel = cur_q;
  assign game_init    = init_q;

endmodule

// File: doc/game_mode_ctrl.md
GAME_MODE_CTRL -- requirements
Module: game_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 250000, is the number of clk cycles a button must stay stable to be accepted (10 ms at 25 MHz).
REQ-002 Parameter OVER_HOLD_CYC, default 75000000, is the number of clk cycles the game-over screen is held before returning to the start screen (3 s at 25 MHz).
REQ-003 Port clk, input, 1, single system and pixel clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port btn_sel_raw, input, 1, raw menu-select button, active-high, asynchronous to clk.
REQ-006 Port btn_start_raw, input, 1, raw start/confirm button, active-high, asynchronous to clk.
REQ-007 Port player_dead, input, 1, level from game logic, synchronous to clk; 1 means the player has no lives left.
REQ-008 Port mode, output, 3, current screen: 0 = start, 1 = one-player game, 2 = two-player game, 3 = game over.
REQ-009 Port btn_mode_sel, output, 1, menu cursor: 1 = upper item (one-player), 0 = lower item (two-player).
REQ-010 Port game_init, output, 1, one-cycle pulse telling the game logic to reinitialise.

Function
REQ-011 Each raw button SHALL pass through a 2-flop synchroniser and then a stability counter; the debounced level SHALL change only after DEBOUNCE_CYC consecutive cycles of a new synchronised value.
REQ-012 A press SHALL be a one-cycle pulse on the 0->1 edge of the debounced level; holding a button SHALL NOT generate further presses.
REQ-013 The FSM SHALL have exactly four states, S_START, S_PLAY1, S_PLAY2 and S_OVER, driving mode 0/1/2/3 respectively from a register.
REQ-014 In S_START, a sel press SHALL toggle btn_mode_sel.
REQ-015 In S_START, a start press SHALL go to S_PLAY1 if btn_mode_sel = 1, otherwise to S_PLAY2.
REQ-016 If sel and start presses occur in the same cycle in S_START, start SHALL win and use the pre-toggle cursor, and the cursor SHALL NOT toggle.
REQ-017 game_init SHALL pulse high for exactly one cycle, in the first cycle mode shows 1 or 2.
REQ-018 In S_PLAY1 or S_PLAY2, player_dead = 1 SHALL go to S_OVER on the next edge; sel and start presses SHALL be ignored.
REQ-019 On entry to S_OVER, a hold counter SHALL clear and then increment every cycle.
REQ-020 S_OVER SHALL go to S_START when the hold counter reaches OVER_HOLD_CYC-1, or earlier on a start press.
REQ-021 On any transition into S_START, btn_mode_sel SHALL be set to 1.
REQ-022 player_dead SHALL be ignored in S_START and S_OVER.
REQ-023 Every counter SHALL be $clog2(parameter) bits wide and SHALL saturate or clear, never wrap.
REQ-024 Output latency SHALL be one clk from the accepted press or player_dead edge to the mode change.

Reset
REQ-025 While rst_n = 0, the block SHALL hold: state S_START, mode 0, btn_mode_sel 1, game_init 0, all counters 0, synchronisers and debounced levels 0.
REQ-026 Reset asserted mid-game or mid-hold SHALL return the block to S_START immediately, with no game_init pulse.
REQ-027 After rst_n deasserts, a button already held SHALL produce a press only after DEBOUNCE_CYC stable cycles.

Structure
REQ-028 Mode encodings (MODE_START = 0, MODE_PLAY1 = 1, MODE_PLAY2 = 2, MODE_OVER = 3) SHALL live in the shared game_defs package, which game_background's mode consumers also use.
REQ-029 The synchroniser, debounce counter and edge detector SHALL be one sub-module, btn_debounce, instantiated twice.

Verification (DEBOUNCE_CYC = 4, OVER_HOLD_CYC = 20)
REQ-030 From reset, press sel for 10 cycles -> btn_mode_sel becomes 0; press sel again -> becomes 1; a 3-cycle glitch -> no change.
REQ-031 With btn_mode_sel = 0, press start -> mode becomes 2 and game_init is high for exactly one cycle; holding start for 50 cycles -> no further effect.
REQ-032 In mode 1, raise player_dead -> mode becomes 3 next cycle; with no press, mode returns to 0 exactly 20 cycles after entering 3, and btn_mode_sel = 1.
REQ-033 In mode 3, press start at cycle 5 of the hold -> mode becomes 0 one cycle after the debounced edge.
REQ-034 In S_START with cursor 1, sel and start become stable in the same cycle -> mode becomes 1 and cursor stays 1.
REQ-035 In mode 2, assert rst_n low asynchronously between edges -> mode is 0 immediately, and game_init stays 0 through release.
